// File: rtl/raw_pkg.sv
// raw_pkg: constants and types shared by the raw 5-stream combiner and splitter.
//   N_LANES   - lanes per combined beat
//   DATA_W    - sample width per lane
//   CH_W      - channel-tag width per lane
//   CH_STRIDE - channel offset between adjacent lanes (RHD2132 channels per stream)
//   LAST_CH   - channel number that closes a full sweep
package raw_pkg;

  localparam int unsigned N_LANES   = 5;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned CH_W      = 12;
  localparam int unsigned CH_STRIDE = 32;
  localparam int unsigned LAST_CH   = 159;

  typedef logic [DATA_W-1:0] raw_sample_t;
  typedef logic [CH_W-1:0]   raw_ch_t;

  typedef enum logic {
    EMPTY = 1'b0,
    SHIFT = 1'b1
  } split_state_t;

endpackage

// File: rtl/raw_ch_checker.sv
// raw_ch_checker: channel-tag consistency check for combined raw beats.
// On every accepted beat, lane k tag must equal lane-0 tag + k*CH_STRIDE
// (mod 2^CH_W), and lane-0 tag must follow the previous lane-0 tag by one
// (mod CH_STRIDE); the sequence check is skipped for the first beat after reset.
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   accept      - combined beat accepted this cycle
//   tags        - lane k tag at [CH_W*k +: CH_W]
//   ch_err      - one-cycle pulse the cycle after a violating accept
//   ch_err_cnt  - saturating count of violating beats
module raw_ch_checker
  import raw_pkg::*;
#(
  parameter int unsigned N_LANES   = raw_pkg::N_LANES,
  parameter int unsigned CH_W      = raw_pkg::CH_W,
  parameter int unsigned CH_STRIDE = raw_pkg::CH_STRIDE
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    accept,
  input  logic [N_LANES*CH_W-1:0] tags,
  output logic                    ch_err,
  output logic [15:0]             ch_err_cnt
);

  logic [N_LANES-1:0][CH_W-1:0] lane_tag;
  logic [CH_W-1:0]              prev_tag0;
  logic                         have_prev;
  logic                         viol;

  assign lane_tag = tags;

  always_comb begin
    viol = 1'b0;
    for (int unsigned k = 1; k < N_LANES; k++) begin
      if (lane_tag[k] != CH_W'(lane_tag[0] + k * CH_STRIDE)) viol = 1'b1;
    end
    if (have_prev && (lane_tag[0] != CH_W'((prev_tag0 + 1) % CH_STRIDE))) viol = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_err     <= 1'b0;
      ch_err_cnt <= '0;
      prev_tag0  <= '0;
      have_prev  <= 1'b0;
    end else begin
      ch_err <= accept && viol;
      if (accept) begin
        prev_tag0 <= lane_tag[0];
        have_prev <= 1'b1;
        if (viol && (ch_err_cnt != '1)) ch_err_cnt <= ch_err_cnt + 16'd1;
      end
    end
  end

endmodule

// File: rtl/raw_split_5_streams.sv
// raw_split_5_streams: splits one combined AXI4-Stream beat (N_LANES samples
// plus N_LANES channel tags) into N_LANES single-sample beats, lane 0 first,
// at full throughput (lane 4 handshake and next accept share a cycle).
// Optional feature macro: RAW_SPLIT_CH_CHECK_EN enables the channel-tag checker;
// without it ch_err and ch_err_cnt are tied to zero.
// Ports:
//   bus_clk, reset                        - clock, asynchronous active-high reset
//   comb_valid/comb_ready/comb_data/comb_ch - combined input stream
//   ser_valid/ser_ready/ser_data/ser_ch/ser_last - serialized output stream
//   busy        - holding register occupied
//   ch_err      - channel-consistency violation pulse
//   ch_err_cnt  - saturating violation count
module raw_split_5_streams
  import raw_pkg::*;
#(
  parameter int unsigned N_LANES   = raw_pkg::N_LANES,
  parameter int unsigned DATA_W    = raw_pkg::DATA_W,
  parameter int unsigned CH_W      = raw_pkg::CH_W,
  parameter int unsigned CH_STRIDE = raw_pkg::CH_STRIDE,
  parameter int unsigned LAST_CH   = raw_pkg::LAST_CH
) (
  input  logic                      bus_clk,
  input  logic                      reset,
  input  logic                      comb_valid,
  output logic                      comb_ready,
  input  logic [N_LANES*DATA_W-1:0] comb_data,
  input  logic [N_LANES*CH_W-1:0]   comb_ch,
  output logic                      ser_valid,
  input  logic                      ser_ready,
  output logic [DATA_W-1:0]         ser_data,
  output logic [CH_W-1:0]           ser_ch,
  output logic                      ser_last,
  output logic                      busy,
  output logic                      ch_err,
  output logic [15:0]               ch_err_cnt
);

  localparam int unsigned LANE_W = (N_LANES > 1) ? $clog2(N_LANES) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(N_LANES - 1);

  split_state_t state_q, state_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic [N_LANES-1:0][DATA_W-1:0] hold_data;
  logic [N_LANES-1:0][CH_W-1:0]   hold_ch;
  logic full;
  logic accept;
  logic out_hs;
  logic load;

  assign full       = (state_q == SHIFT);
  assign comb_ready = !full || ((lane_q == LAST_LANE) && ser_ready);
  assign accept     = comb_valid && comb_ready;
  assign out_hs     = full && ser_ready;

  assign ser_valid = full;
  assign ser_data  = hold_data[lane_q];
  assign ser_ch    = hold_ch[lane_q];
  assign ser_last  = full && (ser_ch == CH_W'(LAST_CH));
  assign busy      = full;

  // An accept while full can only happen on the lane-4 handshake, so
  // checking accept first covers the reload case without a bubble.
  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    load    = 1'b0;
    if (accept) begin
      load    = 1'b1;
      state_d = SHIFT;
      lane_d  = '0;
    end else if (out_hs) begin
      if (lane_q != LAST_LANE) begin
        lane_d = lane_q + LANE_W'(1);
      end else begin
        state_d = EMPTY;
        lane_d  = '0;
      end
    end
  end

  always_ff @(posedge bus_clk or posedge reset) begin
    if (reset) begin
      state_q   <= EMPTY;
      lane_q    <= '0;
      hold_data <= '0;
      hold_ch   <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      if (load) begin
        hold_data <= comb_data;
        hold_ch   <= comb_ch;
      end
    end
  end

`ifdef RAW_SPLIT_CH_CHECK_EN
  raw_ch_checker #(
    .N_LANES   (N_LANES),
    .CH_W      (CH_W),
    .CH_STRIDE (CH_STRIDE)
  ) u_ch_checker (
    .clk        (bus_clk),
    .rst        (reset),
    .accept     (accept),
    .tags       (comb_ch),
    .ch_err     (ch_err),
    .ch_err_cnt (ch_err_cnt)
  );
`else
  assign ch_err     = 1'b0;
  assign ch_err_cnt = '0;
`endif

endmodule

// File: tb/tb_raw_split_5_streams.sv
// tb_raw_split_5_streams: self-checking bench for raw_split_5_streams.
// A queue-based model of pending output beats is compared against the DUT on
// every falling edge; directed tests add literal expectations.
module tb_raw_split_5_streams;

  logic        bus_clk = 1'b0;
  logic        reset;
  logic        comb_valid;
  logic        comb_ready;
  logic [79:0] comb_data;
  logic [59:0] comb_ch;
  logic        ser_valid;
  logic        ser_ready;
  logic [15:0] ser_data;
  logic [11:0] ser_ch;
  logic        ser_last;
  logic        busy;
  logic        ch_err;
  logic [15:0] ch_err_cnt;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 bus_clk = ~bus_clk;

  raw_split_5_streams dut (
    .bus_clk    (bus_clk),
    .reset      (reset),
    .comb_valid (comb_valid),
    .comb_ready (comb_ready),
    .comb_data  (comb_data),
    .comb_ch    (comb_ch),
    .ser_valid  (ser_valid),
    .ser_ready  (ser_ready),
    .ser_data   (ser_data),
    .ser_ch     (ser_ch),
    .ser_last   (ser_last),
    .busy       (busy),
    .ch_err     (ch_err),
    .ch_err_cnt (ch_err_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  typedef struct packed {
    logic [15:0] d;
    logic [11:0] c;
  } beat_t;

  beat_t       q[$];
  int          cyc = 0;
  int unsigned out_cnt = 0;
  int unsigned mark_cnt = 0;
  int          first_hs_cyc = 0;
  int          last_hs_cyc = 0;
  int unsigned last_cnt = 0;
  int unsigned err_pulses = 0;
  logic        exp_err = 1'b0;
  logic [15:0] exp_cnt = '0;
  logic        have_prev = 1'b0;
  int          prev_tag0 = 0;

  always @(negedge bus_clk) begin
    logic exp_valid, exp_cready, next_err, viol;
    int   t0;
    beat_t b;
    cyc++;
    if (ch_err === 1'b1) err_pulses++;
    if (reset) begin
      chk("rst_comb_ready", comb_ready, 1);
      chk("rst_ser_valid", ser_valid, 0);
      chk("rst_ser_data", ser_data, 0);
      chk("rst_ser_ch", ser_ch, 0);
      chk("rst_ser_last", ser_last, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ch_err", ch_err, 0);
      chk("rst_ch_err_cnt", ch_err_cnt, 0);
      q.delete();
      exp_err = 1'b0;
      exp_cnt = '0;
      have_prev = 1'b0;
    end else begin
      exp_valid  = (q.size() != 0);
      exp_cready = (q.size() == 0) || ((q.size() == 1) && ser_ready);
      chk("ser_valid", ser_valid, exp_valid);
      chk("comb_ready", comb_ready, exp_cready);
      chk("busy", busy, exp_valid);
      if (exp_valid) begin
        chk("ser_data", ser_data, q[0].d);
        chk("ser_ch", ser_ch, q[0].c);
        chk("ser_last", ser_last, q[0].c == 12'd159);
      end else begin
        chk("ser_last_idle", ser_last, 0);
      end
      chk("ch_err", ch_err, exp_err);
      chk("ch_err_cnt", ch_err_cnt, exp_cnt);

      next_err = 1'b0;
      if (exp_valid && ser_ready) begin
        if (out_cnt == mark_cnt) first_hs_cyc = cyc;
        last_hs_cyc = cyc;
        out_cnt++;
        if (ser_last === 1'b1) last_cnt++;
        void'(q.pop_front());
      end
      if (comb_valid && exp_cready) begin
        t0 = int'(comb_ch[11:0]);
        viol = 1'b0;
        for (int k = 0; k < 5; k++) begin
          b.d = comb_data[k*16 +: 16];
          b.c = comb_ch[k*12 +: 12];
          q.push_back(b);
          if (int'(b.c) != ((t0 + 32 * k) % 4096)) viol = 1'b1;
        end
        if (have_prev && (t0 != ((prev_tag0 + 1) % 32))) viol = 1'b1;
        have_prev = 1'b1;
        prev_tag0 = t0;
`ifdef RAW_SPLIT_CH_CHECK_EN
        next_err = viol;
`endif
      end
      exp_err = next_err;
      if (next_err && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [79:0] mk_data(input logic [15:0] base);
    logic [79:0] r;
    for (int k = 0; k < 5; k++) r[k*16 +: 16] = base + 16'(k);
    return r;
  endfunction

  function automatic logic [59:0] mk_ch(input int tag0);
    logic [59:0] r;
    for (int k = 0; k < 5; k++) r[k*12 +: 12] = 12'(tag0 + 32 * k);
    return r;
  endfunction

  task automatic send_beat(input logic [79:0] d, input logic [59:0] c);
    logic acc;
    comb_data  = d;
    comb_ch    = c;
    comb_valid = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge bus_clk);
      acc = comb_ready;
      @(posedge bus_clk);
      #1;
    end
    if (!acc) chk("accept_timeout", acc, 1);
    comb_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge bus_clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge bus_clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1);
  end

  initial begin
    int unsigned base_last, base_err;
    reset      = 1'b1;
    comb_valid = 1'b0;
    comb_data  = '0;
    comb_ch    = '0;
    ser_ready  = 1'b1;
    repeat (3) @(posedge bus_clk);
    #1 reset = 1'b0;
    @(negedge bus_clk);
    chk("init_comb_ready", comb_ready, 1);
    chk("init_ser_valid", ser_valid, 0);
    chk("init_busy", busy, 0);
    @(posedge bus_clk);
    #1;

    // Single beat: samples 1..5, tags 0,32,64,96,128
    send_beat(80'h0005_0004_0003_0002_0001, {12'd128, 12'd96, 12'd64, 12'd32, 12'd0});
    for (int i = 0; i < 5; i++) begin
      @(negedge bus_clk);
      chk("single_valid", ser_valid, 1);
      chk("single_data", ser_data, 64'(i + 1));
      chk("single_ch", ser_ch, 64'(32 * i));
      chk("single_last", ser_last, 0);
    end
    @(negedge bus_clk);
    chk("single_drained", ser_valid, 0);

    // Back-to-back full sweep
    pulse_reset();
    mark_cnt  = out_cnt;
    base_last = last_cnt;
    for (int j = 0; j < 32; j++) send_beat(mk_data(16'(j * 256)), mk_ch(j));
    repeat (6) @(negedge bus_clk);
    chk("b2b_beats", out_cnt - mark_cnt, 160);
    chk("b2b_contiguous", last_hs_cyc - first_hs_cyc, 159);
    chk("b2b_last_once", last_cnt - base_last, 1);
    @(posedge bus_clk);
    #1;

    // Stall on lane 2 for 3 cycles, then stall lane 4 with a pending beat
    send_beat(mk_data(16'hA000), mk_ch(0));
    repeat (2) @(posedge bus_clk);
    #1 ser_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge bus_clk);
      chk("stall_data", ser_data, 16'hA002);
      chk("stall_ch", ser_ch, 12'd64);
      chk("stall_comb_ready", comb_ready, 0);
    end
    @(posedge bus_clk);
    #1 ser_ready = 1'b1;
    @(posedge bus_clk);
    #1;
    @(negedge bus_clk);
    chk("resume_lane3", ser_data, 16'hA003);
    @(posedge bus_clk);
    #1;
    ser_ready  = 1'b0;
    comb_data  = mk_data(16'hB000);
    comb_ch    = mk_ch(1);
    comb_valid = 1'b1;
    @(negedge bus_clk);
    chk("lane4_stall_comb_ready", comb_ready, 0);
    @(posedge bus_clk);
    #1 ser_ready = 1'b1;
    @(negedge bus_clk);
    chk("lane4_go_comb_ready", comb_ready, 1);
    @(posedge bus_clk);
    #1 comb_valid = 1'b0;
    @(negedge bus_clk);
    chk("reload_lane0", ser_data, 16'hB000);
    repeat (5) @(posedge bus_clk);
    #1;

    // Reset after lane 1 output
    send_beat(mk_data(16'hC000), mk_ch(2));
    repeat (2) @(posedge bus_clk);
    #1 reset = 1'b1;
    @(negedge bus_clk);
    chk("midrst_ser_valid", ser_valid, 0);
    chk("midrst_comb_ready", comb_ready, 1);
    @(posedge bus_clk);
    #1 reset = 1'b0;

    // Lane 3 tag 97 instead of 96; also first beat after reset starts at lane 0
    base_err = err_pulses;
    send_beat(80'h0005_0004_0003_0002_0001, {12'd128, 12'd97, 12'd64, 12'd32, 12'd0});
    @(negedge bus_clk);
    chk("after_rst_lane0", ser_data, 16'h0001);
    repeat (6) @(negedge bus_clk);
`ifdef RAW_SPLIT_CH_CHECK_EN
    chk("err_pulses", err_pulses - base_err, 1);
    chk("err_cnt", ch_err_cnt, 1);
`else
    chk("err_pulses", err_pulses - base_err, 0);
    chk("err_cnt", ch_err_cnt, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
